// File: rtl/fptopk.sv
// Streaming top-K selector: keeps the K smallest IEEE-754 distances of a frame
// sorted in registers, then emits them smallest first. Optional: FPTOPK_NAN_DROP_EN.
module fptopk #(
  parameter int DW = 32,
  parameter int IW = 4,
  parameter int K  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          iv_i,
  output logic          ir_o,
  input  logic          il_i,
  input  logic [IW-1:0] ii_i,
  input  logic [DW-1:0] id_i,
  output logic          ov_o,
  input  logic          or_i,
  output logic          ol_o,
  output logic [IW-1:0] oi_o,
  output logic [DW-1:0] od_o
);

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] KC = CW'(K);
  localparam logic [DW-1:0] QNAN = {1'b0, {8{1'b1}}, 1'b1, {(DW-10){1'b0}}};

  typedef enum logic {COLLECT, EMIT} state_e;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
    logic [DW-1:0] dat;
  } slot_t;

  state_e           state_q, state_d;
  slot_t  [K-1:0]   slot_q, slot_d;
  logic   [CW-1:0]  cnt_q, cnt_d;
  logic   [K-1:0]   le;
  logic   [DW-1:0]  knew;
  slot_t            new_s;
  logic             do_ins, do_pop, do_clr, nan_blk, empty_emit;

  // Monotone unsigned key: -0 folds onto +0, every NaN sits above +inf.
  function automatic logic [DW-1:0] fkey(input logic [DW-1:0] x);
    logic [DW-1:0] c;
    c = x;
    if (c[DW-2:0] == '0) c = '0;
    if ((&x[DW-2:DW-9]) && (|x[DW-10:0])) return '1;
    return c[DW-1] ? ~c : {1'b1, c[DW-2:0]};
  endfunction

`ifdef FPTOPK_NAN_DROP_EN
  logic nan_in;
  assign nan_in     = (&id_i[DW-2:DW-9]) && (|id_i[DW-10:0]);
  assign nan_blk    = nan_in;
  assign empty_emit = (cnt_q == '0);
`else
  assign nan_blk    = 1'b0;
  assign empty_emit = 1'b0;
`endif

  assign knew  = fkey(id_i);
  assign new_s = '{vld: 1'b1, idx: ii_i, dat: id_i};

  assign ir_o = ~rst_i && (state_q == COLLECT);
  assign ov_o = ~rst_i && (state_q == EMIT);
  assign ol_o = ov_o && ((cnt_q == CW'(1)) || empty_emit);
  assign oi_o = (ov_o && !empty_emit) ? slot_q[0].idx : '0;
  assign od_o = !ov_o ? '0 : (empty_emit ? QNAN : slot_q[0].dat);

  // le[K-1] set means the new key ranks after every kept entry: drop it.
  assign do_ins = (state_q == COLLECT) && iv_i && !le[K-1] && !nan_blk;
  assign do_pop = ov_o && or_i;
  assign do_clr = do_pop && ol_o;

  for (genvar g = 0; g < K; g++) begin : g_slot
    slot_t prv, nxt, sd;
    logic  first_gt;
    if (g == 0) begin : g_head
      assign prv      = new_s;
      assign first_gt = 1'b1;
    end else begin : g_body
      assign prv      = slot_q[g-1];
      assign first_gt = le[g-1];
    end
    if (g == K - 1) begin : g_tail
      assign nxt = '0;
    end else begin : g_mid
      assign nxt = slot_q[g+1];
    end

    assign le[g] = slot_q[g].vld && (fkey(slot_q[g].dat) <= knew);

    always_comb begin
      sd = slot_q[g];
      if (do_clr)                sd = '0;
      else if (do_pop)           sd = nxt;
      else if (do_ins && !le[g]) sd = first_gt ? new_s : prv;
    end
    assign slot_d[g] = sd;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: begin
        if (do_ins && (cnt_q != KC)) cnt_d = cnt_q + CW'(1);
        if (iv_i && il_i) state_d = EMIT;
      end
      EMIT: begin
        if (do_clr) begin
          cnt_d   = '0;
          state_d = COLLECT;
        end else if (do_pop && (cnt_q != '0)) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: tb/tb_fptopk.sv
// Directed bench for fptopk: a sort-based frame model checked every cycle,
// plus literal per-frame expectations that pin the model.
module tb_fptopk;
  localparam int DW = 32, IW = 4, K = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          iv_i = 1'b0, il_i = 1'b0, or_i = 1'b0;
  logic [IW-1:0] ii_i = '0;
  logic [DW-1:0] id_i = '0;
  logic          ir_o, ov_o, ol_o;
  logic [IW-1:0] oi_o;
  logic [DW-1:0] od_o;

  always #5 clk = ~clk;

  fptopk #(.DW(DW), .IW(IW), .K(K)) dut (
    .clk_i(clk), .rst_i(rst), .iv_i(iv_i), .ir_o(ir_o), .il_i(il_i),
    .ii_i(ii_i), .id_i(id_i), .ov_o(ov_o), .or_i(or_i), .ol_o(ol_o),
    .oi_o(oi_o), .od_o(od_o)
  );

  typedef struct { logic [IW-1:0] i; logic [DW-1:0] d; } ent_t;
  ent_t frm[$], expq[$], cap[$];
  bit   m_emit = 1'b0, post_rst = 1'b0;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit isnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'h00) return 0.0;
    e = (x[30:23] == 8'hFF) ? 11'h7FF : 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic bit less(input logic [31:0] a, input logic [31:0] b);
    if (isnan(a)) return 1'b0;
    if (isnan(b)) return 1'b1;
    return f2r(a) < f2r(b);
  endfunction

  // Frame model: stable sort of every accepted beat, keep the first K.
  task automatic build_expect();
    ent_t srt[$];
    foreach (frm[n]) begin
      int p = srt.size();
      for (int j = 0; j < srt.size(); j++)
        if (less(frm[n].d, srt[j].d)) begin p = j; break; end
      srt.insert(p, frm[n]);
    end
    expq.delete();
    for (int j = 0; j < srt.size() && j < K; j++) expq.push_back(srt[j]);
    if (expq.size() == 0) expq.push_back('{i: '0, d: 32'h7FC00000});
  endtask

  always @(posedge clk) begin
    post_rst = rst;
    if (rst) begin
      frm.delete(); expq.delete(); m_emit = 1'b0;
    end else if (m_emit) begin
      if (or_i) begin
        void'(expq.pop_front());
        if (expq.size() == 0) m_emit = 1'b0;
      end
    end else if (iv_i) begin
`ifdef FPTOPK_NAN_DROP_EN
      if (!isnan(id_i)) frm.push_back('{i: ii_i, d: id_i});
`else
      frm.push_back('{i: ii_i, d: id_i});
`endif
      if (il_i) begin
        build_expect();
        frm.delete();
        m_emit = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ov", ov_o, 0); chk("rst_ir", ir_o, 0);
      chk("rst_ol", ol_o, 0); chk("rst_oi", oi_o, 0); chk("rst_od", od_o, 0);
    end else begin
      chk("ir", ir_o, !m_emit);
      chk("ov", ov_o, m_emit);
      if (post_rst) begin
        chk("post_rst_ol", ol_o, 0); chk("post_rst_oi", oi_o, 0); chk("post_rst_od", od_o, 0);
      end
      if (ov_o && expq.size() > 0) begin
        chk("oi", oi_o, expq[0].i);
        chk("od", od_o, expq[0].d);
        chk("ol", ol_o, expq.size() == 1);
      end
      if (ov_o && or_i) cap.push_back('{i: oi_o, d: od_o});
    end
  end

  task automatic beat(input logic [IW-1:0] i, input logic [31:0] d, input bit l);
    int n = 0;
    bit ok;
    iv_i = 1'b1; ii_i = i; id_i = d; il_i = l;
    do begin
      ok = ir_o;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("beat_timeout", 1, 0);
    iv_i = 1'b0; il_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    or_i = 1'b1;
    while (m_emit && n < 50) begin @(posedge clk); #1; n++; end
    if (m_emit) chk("drain_timeout", 1, 0);
    or_i = 1'b0;
  endtask

  task automatic lit_n(input int n);
    chk("lit_count", cap.size(), n);
  endtask

  task automatic lit(input int p, input logic [IW-1:0] i, input logic [31:0] d);
    if (p >= cap.size()) chk("lit_missing", p, cap.size());
    else begin
      chk("lit_idx", cap[p].i, i);
      chk("lit_dat", cap[p].d, d);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Mixed signs; fifth beat ranks last and is dropped.
    cap.delete();
    beat(0, 32'h40000000, 0); beat(1, 32'h3F000000, 0); beat(2, 32'hBF800000, 0);
    beat(3, 32'h3F800000, 0); beat(4, 32'h40400000, 1);
    drain();
    lit_n(4); lit(0, 2, 32'hBF800000); lit(1, 1, 32'h3F000000);
    lit(2, 3, 32'h3F800000); lit(3, 0, 32'h40000000);

    // Ties keep arrival order; -0 equals +0.
    cap.delete();
    beat(5, 32'h3F800000, 0); beat(2, 32'h3F800000, 0);
    beat(7, 32'h80000000, 0); beat(1, 32'h00000000, 1);
    drain();
    lit_n(4); lit(0, 7, 32'h80000000); lit(1, 1, 32'h00000000);
    lit(2, 5, 32'h3F800000); lit(3, 2, 32'h3F800000);

    // Descending frame: every beat inserts at the head, the largest falls off.
    cap.delete();
    beat(0, 32'h40A00000, 0); beat(1, 32'h40800000, 0); beat(2, 32'h40400000, 0);
    beat(3, 32'h40000000, 0); beat(4, 32'h3F800000, 1);
    drain();
    lit_n(4); lit(0, 4, 32'h3F800000); lit(1, 3, 32'h40000000);
    lit(2, 2, 32'h40400000); lit(3, 1, 32'h40800000);

    // Single-entry frame held under backpressure.
    cap.delete();
    beat(3, 32'h3F800000, 1);
    repeat (3) begin @(posedge clk); #1; end
    lit_n(0);
    or_i = 1'b1; @(posedge clk); #1; or_i = 1'b0;
    @(posedge clk); #1;
    lit_n(1); lit(0, 3, 32'h3F800000);

    // Back-to-back frames at full rate.
    cap.delete();
    or_i = 1'b1;
    beat(1, 32'h40000000, 0); beat(2, 32'h3F800000, 1);
    beat(3, 32'h40400000, 0); beat(4, 32'hC0000000, 0); beat(5, 32'hBF800000, 1);
    drain();
    lit_n(5); lit(0, 2, 32'h3F800000); lit(1, 1, 32'h40000000);
    lit(2, 4, 32'hC0000000); lit(3, 5, 32'hBF800000); lit(4, 3, 32'h40400000);

    // Reset after the first of four outputs.
    cap.delete();
    beat(0, 32'h3F800000, 0); beat(1, 32'h40000000, 0);
    beat(2, 32'h40400000, 0); beat(3, 32'h40800000, 1);
    or_i = 1'b1; @(posedge clk); #1;
    or_i = 1'b0; rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    beat(6, 32'h40000000, 1);
    drain();
    lit_n(2); lit(0, 0, 32'h3F800000); lit(1, 6, 32'h40000000);

    // NaN above +inf.
    cap.delete();
    beat(1, 32'h7FC00000, 0); beat(2, 32'h7F800000, 1);
    drain();
`ifdef FPTOPK_NAN_DROP_EN
    lit_n(1); lit(0, 2, 32'h7F800000);
`else
    lit_n(2); lit(0, 2, 32'h7F800000); lit(1, 1, 32'h7FC00000);
`endif

    // Frame made of a lone NaN.
    cap.delete();
    beat(1, 32'h7FC00000, 1);
    drain();
`ifdef FPTOPK_NAN_DROP_EN
    lit_n(1); lit(0, 0, 32'h7FC00000);
`else
    lit_n(1); lit(0, 1, 32'h7FC00000);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
